// File: rtl/serial_add_pkg.sv
// Shared types and helpers for the bit-serial adder controller and its full-adder cell.
package serial_add_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int N_DEFAULT           = 8;
  localparam int CELL_SETTLE_DEFAULT = 0;

  // Counter width helper; never returns zero so a 1-value counter still has a bit.
  function automatic int width_min1(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/fa_cell.sv
// Behavioural 1-bit full adder, pin-compatible with the transistor-level cell.
module fa_cell (
  input  logic a,
  input  logic b,
  input  logic c,
  output logic s,
  output logic co
);

  assign s  = a ^ b ^ c;
  assign co = (a & b) | (a & c) | (b & c);

endmodule

// File: rtl/serial_adder_ctrl.sv
// Bit-serial N-bit adder: feeds one LSB-first bit pair per slot into fa_cell,
// recirculates the carry and assembles the sum; start/busy/done handshake.
module serial_adder_ctrl
  import serial_add_pkg::*;
#(
  parameter int N           = N_DEFAULT,
  parameter int CELL_SETTLE = CELL_SETTLE_DEFAULT
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic [N-1:0] op_a,
  input  logic [N-1:0] op_b,
  input  logic         cin,
  output logic         busy,
  output logic         done,
  output logic [N-1:0] sum,
  output logic         cout
);

  localparam int CNT_W  = width_min1(N);
  localparam int SLOT_W = width_min1(CELL_SETTLE + 1);
  localparam logic [CNT_W-1:0]  LAST_BIT  = CNT_W'(N - 1);
  localparam logic [SLOT_W-1:0] LAST_SLOT = SLOT_W'(CELL_SETTLE);

  state_t              state_reg;
  logic [N-1:0]        a_reg;
  logic [N-1:0]        b_reg;
  logic [N-1:0]        sum_sr_reg;
  logic                carry_reg;
  logic [CNT_W-1:0]    cnt_reg;
  logic [SLOT_W-1:0]   slot_reg;
  logic                cell_s;
  logic                cell_co;

  fa_cell u_cell (
    .a  (a_reg[0]),
    .b  (b_reg[0]),
    .c  (carry_reg),
    .s  (cell_s),
    .co (cell_co)
  );

  // Cell outputs are only consumed on the last cycle of a slot, after settling.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg  <= IDLE;
      a_reg      <= '0;
      b_reg      <= '0;
      sum_sr_reg <= '0;
      carry_reg  <= 1'b0;
      cnt_reg    <= '0;
      slot_reg   <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
      sum        <= '0;
      cout       <= 1'b0;
    end else begin
      case (state_reg)
        IDLE: begin
          done <= 1'b0;
          if (start) begin
            a_reg     <= op_a;
            b_reg     <= op_b;
            carry_reg <= cin;
            cnt_reg   <= '0;
            slot_reg  <= '0;
            busy      <= 1'b1;
            state_reg <= RUN;
          end
        end
        RUN: begin
          if (slot_reg == LAST_SLOT) begin
            slot_reg   <= '0;
            sum_sr_reg <= {cell_s, sum_sr_reg[N-1:1]};
            carry_reg  <= cell_co;
            a_reg      <= a_reg >> 1;
            b_reg      <= b_reg >> 1;
            cnt_reg    <= cnt_reg + 1'b1;
            if (cnt_reg == LAST_BIT) begin
              state_reg <= DONE;
            end
          end else begin
            slot_reg <= slot_reg + 1'b1;
          end
        end
        DONE: begin
          done      <= 1'b1;
          busy      <= 1'b0;
          sum       <= sum_sr_reg;
          cout      <= carry_reg;
          state_reg <= IDLE;
        end
        default: begin
          state_reg <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_serial_adder_ctrl.sv
// Scoreboard bench: two instances (CELL_SETTLE 0 and 2) driven by directed vectors.
module tb_serial_adder_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic [1:0]      rst_n;
  logic [1:0]      start;
  logic [1:0]      cin;
  logic [1:0][7:0] op_a;
  logic [1:0][7:0] op_b;
  wire  [1:0]      busy;
  wire  [1:0]      done;
  wire  [1:0]      cout;
  wire  [1:0][7:0] sum;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_cmp = 0;
  int n_bad = 0;

  typedef struct {
    logic [7:0] s;
    logic       c;
    int         at;
  } exp_t;

  exp_t q0[$];
  exp_t q1[$];

  serial_adder_ctrl #(.N(8), .CELL_SETTLE(0)) dut0 (
    .clk(clk), .rst_n(rst_n[0]), .start(start[0]), .op_a(op_a[0]), .op_b(op_b[0]),
    .cin(cin[0]), .busy(busy[0]), .done(done[0]), .sum(sum[0]), .cout(cout[0])
  );

  serial_adder_ctrl #(.N(8), .CELL_SETTLE(2)) dut1 (
    .clk(clk), .rst_n(rst_n[1]), .start(start[1]), .op_a(op_a[1]), .op_b(op_b[1]),
    .cin(cin[1]), .busy(busy[1]), .done(done[1]), .sum(sum[1]), .cout(cout[1])
  );

  function automatic int lat_of(input int d);
    return (d == 0) ? 9 : 25;
  endfunction

  function automatic int qsize(input int d);
    return (d == 0) ? q0.size() : q1.size();
  endfunction

  task automatic cmp(input string name, input int d, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s dut%0d: got 0x%0h required 0x%0h (cycle %0d)", name, d, act, req, cyc);
    end
  endtask

  task automatic push_exp(input int d, input logic [7:0] es, input logic ec, input int at);
    exp_t e;
    e.s  = es;
    e.c  = ec;
    e.at = at;
    if (d == 0) q0.push_back(e);
    else        q1.push_back(e);
  endtask

  task automatic check_done(input int d);
    exp_t e;
    if (qsize(d) == 0) begin
      n_cmp++;
      n_bad++;
      $display("FAIL unexpected_done dut%0d: got done=1 sum=0x%02h required no done (cycle %0d)",
               d, sum[d], cyc);
    end else begin
      if (d == 0) e = q0.pop_front();
      else        e = q1.pop_front();
      cmp("sum", d, 32'(sum[d]), 32'(e.s));
      cmp("cout", d, 32'(cout[d]), 32'(e.c));
      cmp("done_cycle", d, 32'(cyc), 32'(e.at));
      $display("dut%0d done: sum=0x%02h cout=%0b cycle=%0d", d, sum[d], cout[d], cyc);
    end
  endtask

  // Monitor: pops the scoreboard whenever a done pulse is seen.
  always @(negedge clk) begin
    for (int d = 0; d < 2; d++) begin
      if (done[d] === 1'b1) check_done(d);
    end
  end

  task automatic issue(input int d, input logic [7:0] a, input logic [7:0] b, input logic ci,
                       input logic [7:0] es, input logic ec, input bit expect_done, output int acc);
    @(negedge clk);
    op_a[d]  = a;
    op_b[d]  = b;
    cin[d]   = ci;
    start[d] = 1'b1;
    @(posedge clk);
    #1;
    acc      = cyc;
    start[d] = 1'b0;
    cmp("busy_on_accept", d, 32'(busy[d]), 32'd1);
    if (expect_done) push_exp(d, es, ec, acc + lat_of(d));
    $display("dut%0d issue: 0x%02h + 0x%02h + %0b", d, a, b, ci);
  endtask

  task automatic wait_drain(input int d, input int budget);
    int left;
    left = budget;
    while (qsize(d) > 0 && left > 0) begin
      @(posedge clk);
      left--;
    end
    n_cmp++;
    if (qsize(d) > 0) begin
      n_bad++;
      $display("FAIL drain_timeout dut%0d: got %0d pending results required 0", d, qsize(d));
      if (d == 0) q0.delete();
      else        q1.delete();
    end
  endtask

  task automatic check_zero(input string name, input int d);
    cmp({name, "_busy"}, d, 32'(busy[d]), 32'd0);
    cmp({name, "_done"}, d, 32'(done[d]), 32'd0);
    cmp({name, "_sum"},  d, 32'(sum[d]),  32'd0);
    cmp({name, "_cout"}, d, 32'(cout[d]), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no completion required finish before time limit");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int  acc;
    bit  seen;
    rst_n = '0;
    start = '0;
    cin   = '0;
    op_a  = '0;
    op_b  = '0;

    repeat (3) @(posedge clk);
    #1;
    check_zero("reset", 0);
    check_zero("reset", 1);

    @(negedge clk);
    rst_n[0] = 1'b1;
    for (int k = 0; k < 10; k++) begin
      @(posedge clk);
      #1;
      cmp("idle_hold", 0, 32'({busy[0], done[0], cout[0], sum[0]}), 32'd0);
    end

    issue(0, 8'h35, 8'h4A, 1'b0, 8'h7F, 1'b0, 1'b1, acc);
    wait_drain(0, 20);
    issue(0, 8'hFF, 8'h00, 1'b1, 8'h00, 1'b1, 1'b1, acc);
    wait_drain(0, 20);
    issue(0, 8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1, 1'b1, acc);
    wait_drain(0, 20);

    // Start pulses while running and while in DONE must be ignored.
    issue(0, 8'h11, 8'h22, 1'b0, 8'h33, 1'b0, 1'b1, acc);
    for (int k = 1; k <= 9; k++) begin
      @(negedge clk);
      op_a[0]  = 8'hAA;
      op_b[0]  = 8'h55;
      cin[0]   = 1'b1;
      start[0] = (k == 3 || k == 8 || k == 9);
      @(posedge clk);
      #1;
      start[0] = 1'b0;
      cmp("busy_during_op", 0, 32'(busy[0]), (k < 9) ? 32'd1 : 32'd0);
    end
    wait_drain(0, 20);
    repeat (12) @(posedge clk);

    // Abort mid-run: outputs clear at once and no done follows.
    issue(0, 8'hC3, 8'h3C, 1'b0, 8'h00, 1'b0, 1'b0, acc);
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n[0] = 1'b0;
    #1;
    check_zero("abort", 0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n[0] = 1'b1;
    repeat (15) @(posedge clk);
    #1;
    cmp("abort_idle_busy", 0, 32'(busy[0]), 32'd0);
    issue(0, 8'h12, 8'h34, 1'b0, 8'h46, 1'b0, 1'b1, acc);
    wait_drain(0, 20);

    // Settle cycles plus back-to-back issue right after done.
    @(negedge clk);
    rst_n[1] = 1'b1;
    issue(1, 8'h80, 8'h80, 1'b0, 8'h00, 1'b1, 1'b1, acc);
    seen = 1'b0;
    for (int k = 0; k < 40 && !seen; k++) begin
      @(negedge clk);
      if (done[1] === 1'b1) seen = 1'b1;
    end
    n_cmp++;
    if (!seen) begin
      n_bad++;
      $display("FAIL settle_done_timeout dut1: got no done required done within 40 cycles");
    end else begin
      op_a[1]  = 8'h01;
      op_b[1]  = 8'h01;
      cin[1]   = 1'b0;
      start[1] = 1'b1;
      @(posedge clk);
      #1;
      acc      = cyc;
      start[1] = 1'b0;
      cmp("b2b_accept_busy", 1, 32'(busy[1]), 32'd1);
      push_exp(1, 8'h02, 1'b0, acc + lat_of(1));
      $display("dut1 issue: 0x01 + 0x01 + 0 (back-to-back)");
    end
    wait_drain(1, 40);
    repeat (5) @(posedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
